perf_session_ctrl: RTL
======================

# perf_session_ctrl

Sequencer that owns the measurement window of the pipeline performance counter bank. It opens counting on a start request, keeps counting through a fixed drain period after the core signals end of program, then freezes the counters. It then streams every counter word out over a valid/ready port to the testbench/MMIO sink. It sits between the core's halt/zero-detect logic and the counter bank, and drives the bank's enable and read-select.

## Interface
- NUM_CNT, 9, number of counter words in the bank (cycles, instructions, stalls, bubbles, forwards, raw_hazards, cond_branches, uncond_branches, cond_mispred; index order fixed)
- IDX_W, 4, width of counter index; must satisfy 2^IDX_W > NUM_CNT
- DRAIN_CYCLES, 10, cycles counting stays enabled after halt is seen (1..255)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request to open the measurement window (level, sampled in IDLE only)
- halt_detect  in  1  core end-of-program indication (sampled in RUN only)
- perf_enable  out  1  counter bank enable (registered)
- cnt_sel  out  IDX_W  counter bank read select
- cnt_data  in  32  counter bank read data, combinational from cnt_sel
- out_valid  out  1  stream word valid
- out_ready  in  1  sink accepts word
- out_idx  out  IDX_W  index of current word
- out_data  out  32  current word
- busy  out  1  high in RUN, DRAIN, DUMP
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DRAIN, DUMP, DONE. Reset → IDLE.
- IDLE: start=1 → RUN.
- RUN: perf_enable=1. halt_detect=1 → DRAIN, drain counter loaded with DRAIN_CYCLES-1.
- DRAIN: perf_enable=1; drain counter decrements each cycle; at 0 → DUMP with idx=0.
- DUMP: perf_enable=0 (counters frozen). cnt_sel=idx, out_idx=idx, out_data=cnt_data, out_valid=1. Transfer when out_valid&&out_ready: idx increments; transfer of idx=NUM_CNT-1 (last word) → DONE.
- DONE: terminal; out_valid=0, done=1; start ignored. Leaving DONE requires rst.
- start outside IDLE and halt_detect outside RUN are ignored. halt_detect in the same cycle start is accepted is ignored (not yet in RUN).
- idx never wraps; it saturates at the last index.

## Timing
- Reset values: perf_enable=0, cnt_sel=0, out_valid=0, out_idx=0, out_data=cnt_data pass-through (don't-care), busy=0, done=0.
- start sampled at edge N in IDLE → perf_enable=1 from cycle N+1.
- halt_detect sampled at edge H in RUN → perf_enable stays high for exactly DRAIN_CYCLES cycles after H, low from H+DRAIN_CYCLES+1. The counter bank counts the halt cycle plus DRAIN_CYCLES.
- First out_valid is in the same cycle perf_enable falls. Minimum dump length is NUM_CNT cycles with out_ready tied high.
- out_valid, once asserted, stays asserted with out_idx/out_data stable until accepted; out_ready while out_valid=0 has no effect.
- rst at any point (including mid-DUMP with a pending word) → IDLE next cycle. The pending word is dropped with no partial transfer.

## Configuration
- PERF_SESSION_CHECKSUM_EN defined: after the last counter word, one extra word is sent with out_idx=NUM_CNT and out_data equal to the XOR of all NUM_CNT transferred words. It is accumulated in a 32-bit register cleared on entry to DUMP and updated on each transfer. DONE is entered on acceptance of that word.
- Undefined: no checksum register; DONE is entered after word NUM_CNT-1.

## Structure
- Shared package perf_pkg: state enum encoding, counter index constants (IDX_CYCLES=0 … IDX_COND_MISPRED=8), NUM_CNT default.
- One natural sub-module: perf_drain_timer (loadable 8-bit down-counter with zero flag) used in DRAIN. The FSM, index and checksum logic stay in the top.

## Test plan
- start=1 for 1 cycle, halt_detect pulse 20 cycles later, out_ready=1 → perf_enable high for 1+20+10 cycles total; 9 words idx 0..8 on consecutive cycles; done=1.
- Same run with out_ready toggling 1,0,0,1… → each word is held stable while out_ready=0; no index skipped or duplicated; 9 transfers.
- halt_detect asserted in IDLE and DONE, start asserted in RUN/DUMP → no state change; perf_enable and done unaffected.
- DRAIN_CYCLES=1 → perf_enable falls 2 cycles after the halt edge; first out_valid is in that same cycle.
- rst asserted during DUMP at idx=4 → next cycle out_valid=0, busy=0, IDLE; a new start restarts from idx=0.
- With PERF_SESSION_CHECKSUM_EN and cnt_data=idx+1 → 10th word has out_idx=9 and out_data=0x00000001 (1^2^…^9); done only after it is accepted.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding and counter-bank index map for the perf session controller
package perf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;
  localparam int NUM_CNT_DEF = 9;
  localparam int IDX_CYCLES = 0;
  localparam int IDX_INSTRUCTIONS = 1;
  localparam int IDX_STALLS = 2;
  localparam int IDX_BUBBLES = 3;
  localparam int IDX_FORWARDS = 4;
  localparam int IDX_RAW_HAZARDS = 5;
  localparam int IDX_COND_BRANCHES = 6;
  localparam int IDX_UNCOND_BRANCHES = 7;
  localparam int IDX_COND_MISPRED = 8;
endpackage

// File: rtl/perf_drain_timer.sv
// perf_drain_timer: loadable 8-bit down-counter with zero flag
module perf_drain_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 8'd0) cnt <= cnt - 8'd1;
  assign zero = cnt == 8'd0;
endmodule

// File: rtl/perf_session_ctrl.sv
// perf_session_ctrl: measurement-window sequencer and counter dump streamer.
// Define PERF_SESSION_CHECKSUM_EN to append an XOR checksum word after the counters.
module perf_session_ctrl
  import perf_pkg::*;
#(
  parameter int NUM_CNT      = NUM_CNT_DEF,
  parameter int IDX_W        = 4,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_detect,
  output logic             perf_enable,
  output logic [IDX_W-1:0] cnt_sel,
  input  logic [31:0]      cnt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic drain_zero, xfer;
  assign xfer = out_valid && out_ready;
  perf_drain_timer u_drain (
    .clk(clk),
    .rst(rst),
    .load(state == S_RUN && halt_detect),
    .dec(state == S_DRAIN),
    .load_val(8'(DRAIN_CYCLES - 1)),
    .zero(drain_zero)
  );
`ifdef PERF_SESSION_CHECKSUM_EN
  localparam int LAST = NUM_CNT;
  logic [31:0] csum;
  always_ff @(posedge clk)
    if (rst || (state == S_DRAIN && drain_zero)) csum <= '0;
    else if (xfer && idx != IDX_W'(NUM_CNT)) csum <= csum ^ cnt_data;
  assign out_data = idx == IDX_W'(NUM_CNT) ? csum : cnt_data;
`else
  localparam int LAST = NUM_CNT - 1;
  assign out_data = cnt_data;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state       <= S_IDLE;
      perf_enable <= 1'b0;
      out_valid   <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state       <= S_RUN;
          perf_enable <= 1'b1;
        end
        S_RUN: if (halt_detect) state <= S_DRAIN;
        S_DRAIN: if (drain_zero) begin
          state       <= S_DUMP;
          perf_enable <= 1'b0;
          out_valid   <= 1'b1;
          idx         <= '0;
        end
        S_DUMP: if (xfer) begin
          if (idx == IDX_W'(LAST)) begin
            state     <= S_DONE;
            out_valid <= 1'b0;
          end else idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  assign cnt_sel = idx;
  assign out_idx = idx;
  assign busy    = state == S_RUN || state == S_DRAIN || state == S_DUMP;
  assign done    = state == S_DONE;
endmodule
